fb_port_arbiter: RTL and testbench

- Owns the single-port frame-buffer RAM (1-cycle read latency) between the JPEG byte-stream writer and the SPI slave read port.
- Writer side is valid/ready; the arbiter generates sequential write addresses itself.
- SPI reads always have priority and are fully pipelined.
- A two-state frame-lock FSM freezes the buffer once a frame is complete, so the SPI host reads a stable image; the frame length is latched for the host.

---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_port_arbiter_rd_pipe.sv | 59 +++++
 rtl/fb_port_arbiter.sv | 123 ++++++++++++
 tb/tb_fb_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer port arbiter.
//   FB_ADDR_W  : default RAM address width (matches the SPI slave mem_addr)
//   FB_RD_LAT  : read latency of the frame-buffer RAM in clock cycles
//   fb_state_e : frame-lock FSM state encoding
package fb_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_RD_LAT = 1;

    typedef enum logic {
        FB_FILL   = 1'b0,
        FB_LOCKED = 1'b1
    } fb_state_e;

endpackage

// File: rtl/fb_port_arbiter_rd_pipe.sv
// Read pipeline for the frame-buffer port: captures the SPI read request,
// holds the RAM on the read address for one cycle, then captures the RAM
// data and pulses rd_valid_o.
//   clk, reset_n  : clock, asynchronous active-low reset
//   rd_req_i      : single-cycle read pulse
//   rd_addr_i     : read address, sampled with rd_req_i
//   ram_rdata_i   : RAM read data (FB_RD_LAT cycles after the address)
//   rd_pend_o     : a read owns the RAM address port this cycle
//   rd_addr_o     : captured read address to drive onto the RAM
//   rd_data_o     : last read byte, held until the next read completes
//   rd_valid_o    : one-cycle pulse when rd_data_o updates
module fb_rd_pipe
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [7:0]        ram_rdata_i,
    output logic              rd_pend_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [7:0]        rd_data_o,
    output logic              rd_valid_o
);

    // Stage 1: address on the RAM; stage STAGES: RAM data is valid.
    localparam int STAGES = FB_RD_LAT + 1;

    logic [STAGES:1]   vld_pipe_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], rd_req_i};
            if (rd_req_i) begin
                rd_addr_q <= rd_addr_i;
            end
            if (vld_pipe_q[STAGES]) begin
                rd_data_q <= ram_rdata_i;
            end
            rd_valid_q <= vld_pipe_q[STAGES];
        end
    end

    assign rd_pend_o  = vld_pipe_q[1];
    assign rd_addr_o  = rd_addr_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares one single-port RAM between the JPEG
// byte-stream writer (valid/ready, sequential addresses) and the SPI slave
// read port (pipelined, always wins). Once a frame completes (wr_last or
// buffer full) the buffer is locked until the host releases it.
//   clk, reset_n                : clock, asynchronous active-low reset
//   wr_valid/wr_data/wr_last    : writer byte stream
//   wr_ready                    : byte accepted this cycle
//   rd_req/rd_addr              : SPI read request
//   rd_data/rd_valid            : SPI read response (3-cycle latency)
//   frame_release               : host done with the locked frame
//   frame_ready/len/trunc       : locked-frame status for the host
//   ram_addr/we/wdata/rdata     : single-port RAM interface
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DEPTH  = 131072
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              frame_release,
    output logic              frame_ready,
    output logic [ADDR_W:0]   frame_len,
    output logic              frame_trunc,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

    fb_state_e         state_q, state_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]   frame_len_q, frame_len_d;
    logic              frame_trunc_q, frame_trunc_d;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              wr_accept;

    fb_rd_pipe #(
        .ADDR_W (ADDR_W)
    ) u_rd_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .ram_rdata_i (ram_rdata),
        .rd_pend_o   (rd_pend),
        .rd_addr_o   (rd_addr_q),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid)
    );

    // Registers only, so the writer never sees a combinational path from
    // its own valid back to ready. A read in flight steals exactly one cycle.
    assign wr_ready  = (state_q == FB_FILL) && !rd_pend;
    assign wr_accept = wr_valid && wr_ready;

    assign ram_we    = wr_accept;
    assign ram_wdata = wr_data;
    assign ram_addr  = rd_pend ? rd_addr_q : wr_cnt_q[ADDR_W-1:0];

    assign frame_ready = (state_q == FB_LOCKED);
    assign frame_len   = frame_len_q;
    assign frame_trunc = frame_trunc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FB_FILL;
            wr_cnt_q      <= '0;
            frame_len_q   <= '0;
            frame_trunc_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            frame_len_q   <= frame_len_d;
            frame_trunc_q <= frame_trunc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        frame_len_d   = frame_len_q;
        frame_trunc_d = frame_trunc_q;
        case (state_q)
            FB_FILL: begin
                if (wr_accept) begin
                    wr_cnt_d = wr_cnt_q + CNT_ONE;
                    if (wr_last) begin
                        state_d       = FB_LOCKED;
                        frame_len_d   = wr_cnt_q + CNT_ONE;
                        frame_trunc_d = 1'b0;
                    end else if (wr_cnt_q == LAST_IDX) begin
                        // Buffer full without an end marker: lock what we have.
                        state_d       = FB_LOCKED;
                        frame_len_d   = DEPTH_LEN;
                        frame_trunc_d = 1'b1;
                    end
                end
            end
            FB_LOCKED: begin
                if (frame_release) begin
                    state_d  = FB_FILL;
                    wr_cnt_d = '0;
                end
            end
            default: state_d = FB_FILL;
        endcase
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

    localparam int AW    = 5;
    localparam int DEPTH = 8;
    localparam int MSZ   = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_valid, wr_last, wr_ready;
    logic [7:0]    wr_data;
    logic          rd_req, rd_valid;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_release, frame_ready, frame_trunc;
    logic [AW:0]   frame_len;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata, ram_rdata;

    fb_port_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_release(frame_release), .frame_ready(frame_ready),
        .frame_len(frame_len), .frame_trunc(frame_trunc),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM, 1-cycle read latency, with a preload port for the bench.
    logic [7:0]    mem [MSZ];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [7:0]    pl_data;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Reference model: buffer contents and frame status as the host should see them.
    logic [7:0] ref_mem [MSZ];
    int  mdl_cnt = 0;
    bit  mdl_locked = 1'b0;
    int  mdl_len = 0;
    bit  mdl_trunc = 1'b0;
    bit  last_rd;

    typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [7:0] d; int c; } rd_t;
    wr_t wq[$];
    rd_t rq[$];
    wr_t we_e;
    rd_t re_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A read issued in the previous cycle blocks the writer for one cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_rd <= 1'b0;
        else          last_rd <= rd_req;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            rq.delete();
            wq.delete();
        end else begin
            if (ram_we) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr, ram_wdata);
                end else begin
                    we_e = wq.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(we_e.a));
                    chk("wr_data", 32'(ram_wdata), 32'(we_e.d));
                end
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rd_valid: rd_data %0h, no read outstanding", rd_data);
                end else begin
                    re_e = rq.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(re_e.d));
                    chk("rd_latency", 32'(cyc - re_e.c), 32'd3);
                end
            end
            chk("wr_ready", 32'(wr_ready), 32'(!mdl_locked && !last_rd));
            chk("frame_ready", 32'(frame_ready), 32'(mdl_locked));
            chk("frame_len", 32'(frame_len), 32'(mdl_len));
            chk("frame_trunc", 32'(frame_trunc), 32'(mdl_trunc));
        end
    end

    // Reader: directed reads on request, otherwise random per mode.
    // mode 1: only addresses >= DEPTH (safe while the writer streams)
    // mode 2: a read every cycle over the whole RAM (only with no writes)
    int            rd_mode = 0;
    int            dir_cnt = 0;
    logic [AW-1:0] dir_addr;
    initial begin
        int done;
        done = 0;
        rd_req = 1'b0;
        rd_addr = '0;
        forever begin
            @(posedge clk); #1;
            rd_req = 1'b0;
            if (reset_n) begin
                if (done != dir_cnt) begin
                    done = dir_cnt;
                    rd_req = 1'b1;
                    rd_addr = dir_addr;
                end else if (rd_mode == 1 && $urandom_range(3) == 0) begin
                    rd_req = 1'b1;
                    rd_addr = AW'($urandom_range(MSZ - 1, DEPTH));
                end else if (rd_mode == 2) begin
                    rd_req = 1'b1;
                    rd_addr = AW'($urandom_range(MSZ - 1, 0));
                end
                if (rd_req) rq.push_back('{ref_mem[rd_addr], cyc});
            end
        end
    end

    // Offer one byte and hold it until accepted (bounded).
    task automatic send_byte(input logic [7:0] d, input bit last);
        bit acc;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        wq.push_back('{AW'(mdl_cnt), d});
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = wr_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL wr_timeout: byte %0h not accepted, wanted accept within 50 cycles", d);
        end else begin
            ref_mem[mdl_cnt] = d;
            mdl_cnt++;
            if (last) begin
                mdl_locked = 1'b1; mdl_len = mdl_cnt; mdl_trunc = 1'b0;
            end else if (mdl_cnt == DEPTH) begin
                mdl_locked = 1'b1; mdl_len = DEPTH; mdl_trunc = 1'b1;
            end
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic pulse_release();
        frame_release = 1'b1;
        @(posedge clk); #1;
        frame_release = 1'b0;
        if (mdl_locked) begin
            mdl_locked = 1'b0;
            mdl_cnt = 0;
        end
    endtask

    task automatic set_mode(input int m);
        rd_mode = m;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic dir_read(input logic [AW-1:0] a);
        @(negedge clk);
        dir_addr = a;
        dir_cnt++;
        @(posedge clk); #2;   // now inside the cycle the read is issued
    endtask

    task automatic check_reset_values();
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_frame_ready", 32'(frame_ready), 32'd0);
        chk("rst_frame_len", 32'(frame_len), 32'd0);
        chk("rst_frame_trunc", 32'(frame_trunc), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit with_last;
        wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; frame_release = 1'b0;
        // Preload the RAM while in reset.
        for (int i = 0; i < MSZ; i++) begin
            ref_mem[i] = (i == 16) ? 8'h5A : 8'($urandom);
            pl_en = 1'b1; pl_addr = AW'(i); pl_data = ref_mem[i];
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;

        // Frame A0..A4 with wr_last on the last byte, valid held high.
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), i == 4);
        @(negedge clk);
        chk("a_frame_ready", 32'(frame_ready), 32'd1);
        chk("a_frame_len", 32'(frame_len), 32'd5);
        chk("a_wr_ready", 32'(wr_ready), 32'd0);
        chk("a_writes_done", 32'(wq.size()), 32'd0);
        @(posedge clk); #1;

        // Directed read of preloaded 0x10, then data must hold.
        dir_read(AW'(16));
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("hold_rd_data", 32'(rd_data), 32'h5A);
        chk("hold_rd_valid", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;

        // Back-to-back reads while locked; frame bytes must read back.
        set_mode(2);
        repeat (20) @(posedge clk);
        #1;
        set_mode(0);

        // Release, then stray wr_last without valid and a release in FILL.
        pulse_release();
        @(negedge clk);
        chk("rel_frame_len_hold", 32'(frame_len), 32'd5);
        @(posedge clk); #1;
        wr_last = 1'b1;
        @(posedge clk); #1;
        wr_last = 1'b0;
        pulse_release();

        // Randomized frames with reads mixed into the stream.
        for (int f = 0; f < 8; f++) begin
            set_mode(1);
            with_last = (f % 3 != 2);
            n = with_last ? $urandom_range(DEPTH, 1) : DEPTH;
            for (int i = 0; i < n; i++) send_byte(8'($urandom), with_last && (i == n - 1));
            if (!with_last) begin
                // Bytes beyond a full buffer must be ignored.
                wr_valid = 1'b1;
                repeat (5) begin wr_data = 8'($urandom); @(posedge clk); #1; end
                wr_valid = 1'b0;
                chk("trunc_len", 32'(frame_len), 32'(DEPTH));
                chk("trunc_flag", 32'(frame_trunc), 32'd1);
            end
            chk("frame_writes_done", 32'(wq.size()), 32'd0);
            set_mode(2);
            repeat (10) @(posedge clk);
            #1;
            set_mode(0);
            pulse_release();
        end

        // Reset one cycle after a read and mid-frame (wr_cnt = 3).
        dir_read(AW'(16));
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 1'b0);
        dir_read(AW'(20));
        @(posedge clk); #2;
        reset_n = 1'b0;
        mdl_locked = 1'b0; mdl_cnt = 0; mdl_len = 0; mdl_trunc = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_rd_data", 32'(rd_data), 32'd0);
        send_byte(8'hC3, 1'b1);
        @(negedge clk);
        chk("post_rst_len", 32'(frame_len), 32'd1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("final_writes_drained", 32'(wq.size()), 32'd0);
        chk("final_reads_drained", 32'(rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
